instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/core_pkg.sv | 10 +
 rtl/instr_fetch_if.sv | 20 ++
 rtl/fetch_fifo.sv | 43 ++++
 rtl/instr_fetch.sv | 40 ++++
 tb/tb_instr_fetch.sv | 133 +++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared fetch widths, reset PC default and the fetch buffer entry type
package core_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: imem, redirect and decode handshake bundle; master = fetch unit, slave = environment
interface instr_fetch_if;
    import core_pkg::*;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    modport master (
        output imem_addr, out_valid, out_instr, out_pc,
        input  imem_instr, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc,
        output imem_instr, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO of fetch_entry_t (clk, rst, i_push, i_pop, i_flush, i_data -> o_head, o_count)
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_data,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (i_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC register and decode handshake over fetch_fifo (clk, rst, bus = instr_fetch_if.master)
module instr_fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   w_count;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_head;
    assign bus.imem_addr = r_pc;
    assign bus.out_valid = (w_count != '0) && !bus.redirect_valid && !rst;
    assign w_pop         = bus.out_valid && bus.out_ready;
    assign w_push        = !bus.redirect_valid && ((w_count < FULL) || w_pop);
    assign bus.out_instr = w_head.instr;
    assign bus.out_pc    = w_head.pc;
    always_ff @(posedge clk) begin
        r_pc <= rst                ? RESET_PC :
                bus.redirect_valid ? (bus.redirect_pc & ~XLEN'(3)) :
                w_push             ? r_pc + XLEN'(INSTR_BYTES) : r_pc;
    end
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_data  ('{pc: r_pc, instr: bus.imem_instr}),
        .o_head  (w_head),
        .o_count (w_count)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a queue scoreboard checked by a separate output monitor
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];
    instr_fetch_if bus();
    instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h0 ? 32'h0000_0013 : a == 32'h4 ? 32'h0010_0093 : a ^ 32'hDEAD_0013;
    endfunction
    assign bus.imem_instr = mem_word(bus.imem_addr);
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst = r;
        bus.out_ready = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        @(negedge clk);
    endtask
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got pc %h want none", bus.out_pc);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("out_pc", bus.out_pc, e);
                chk("out_instr", bus.out_instr, mem_word(e));
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
    initial begin
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        drive(1, 1, 1, 32'h40);
        drive(1, 1, 0, 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        drive(0, 0, 0, 0);
        chk("c0_addr", bus.imem_addr, 32'h0);
        chk("c0_valid", 32'(bus.out_valid), 0);
        chk("c0_pc_defined", bus.out_pc, 32'h0);
        chk("c0_instr_defined", bus.out_instr, 32'h0);
        drive(0, 0, 0, 0);
        chk("c1_valid", 32'(bus.out_valid), 1);
        chk("c1_pc", bus.out_pc, 32'h0);
        chk("c1_instr", bus.out_instr, 32'h0000_0013);
        chk("c1_addr", bus.imem_addr, 32'h4);
        for (int i = 2; i < 5; i++) begin
            drive(0, 0, 0, 0);
            chk("stall_addr", bus.imem_addr, 32'h8);
            chk("stall_pc", bus.out_pc, 32'h0);
        end
        for (int i = 0; i < 6; i++) sb.push_back(32'(i * 4));
        for (int i = 5; i < 11; i++) begin
            drive(0, 1, 0, 0);
            chk("stream_valid", 32'(bus.out_valid), 1);
        end
        drive(0, 0, 0, 0);
        chk("full_addr", bus.imem_addr, 32'h20);
        drive(0, 0, 1, 32'h100);
        chk("redir_valid", 32'(bus.out_valid), 0);
        drive(0, 0, 0, 0);
        chk("redir_addr", bus.imem_addr, 32'h100);
        chk("redir_valid_n1", 32'(bus.out_valid), 0);
        drive(0, 0, 0, 0);
        chk("redir_valid_n2", 32'(bus.out_valid), 1);
        chk("redir_pc_n2", bus.out_pc, 32'h100);
        drive(0, 0, 1, 32'h200);
        drive(0, 0, 1, 32'h102);
        chk("b2b_valid", 32'(bus.out_valid), 0);
        drive(0, 0, 0, 0);
        chk("unaligned_addr", bus.imem_addr, 32'h100);
        sb.push_back(32'h100);
        sb.push_back(32'h104);
        sb.push_back(32'h108);
        drive(0, 1, 0, 0);
        chk("unaligned_pc", bus.out_pc, 32'h100);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 32'hFFFF_FFFC);
        chk("wrap_redir_valid", 32'(bus.out_valid), 0);
        drive(0, 1, 0, 0);
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        sb.push_back(32'hFFFF_FFFC);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        chk("prefill_valid", 32'(bus.out_valid), 1);
        drive(1, 1, 0, 0);
        chk("midrst_valid", 32'(bus.out_valid), 0);
        drive(0, 1, 0, 0);
        chk("postrst_valid", 32'(bus.out_valid), 0);
        chk("postrst_addr", bus.imem_addr, 32'h0);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
